// File: rtl/alu_pipe_simd.sv
// alu_pipe_simd: two-stage pipelined execute ALU with packed-lane SIMD add and
// lane reduction, valid/ready handshake on both sides.
// Stage 1 captures op/a/b. Stage 2 computes and registers the result and flags.
// Optional build macro ALU_SAT_EN: ADD/SUB and PADD saturate on signed overflow
// instead of wrapping. When it is undefined, every add wraps.
module alu_pipe_simd #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);
    localparam int SH_W   = $clog2(WIDTH);
    localparam int NLANES = WIDTH / LANE_W;
    localparam int MSB    = WIDTH - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_RED  = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;

    // Pipeline registers
    logic             s1_valid_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             flag_z_q;
    logic             flag_v_q;
    logic             flag_n_q;

    // Stage-2 next-state values
    logic [WIDTH-1:0] res_d;
    logic             flag_z_d;
    logic             flag_v_d;
    logic             flag_n_d;

    // Handshake: a stage loads when empty or when its content moves on this cycle
    logic s2_load;
    logic s1_load;

    assign s2_load   = ~s2_valid_q | out_ready;
    assign s1_load   = ~s1_valid_q | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign flag_z    = flag_z_q;
    assign flag_v    = flag_v_q;
    assign flag_n    = flag_n_q;

    // ------------------------------------------------------------------
    // Add/subtract: subtraction is a + ~b + 1 so one adder serves both
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] sum;
    logic             addsub_ovf;
    logic [WIDTH-1:0] addsub_res;

    // Shared adder and its signed-overflow detect
    always_comb begin
        bin        = (op_q == OP_SUB) ? ~b_q : b_q;
        sum        = a_q + bin + {{(WIDTH-1){1'b0}}, (op_q == OP_SUB)};
        addsub_ovf = (a_q[MSB] == bin[MSB]) & (sum[MSB] != a_q[MSB]);
    end

`ifdef ALU_SAT_EN
    // Overflow direction follows the operand sign: both negative clamps to min
    assign addsub_res = addsub_ovf ? (a_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}})
                                   : sum;
`else
    assign addsub_res = sum;
`endif

    // ------------------------------------------------------------------
    // Per-lane logic: PADD lanes and sign-extended lanes for RED
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] padd_res;
    logic [WIDTH-1:0] lane_ext_a [NLANES];
    logic [WIDTH-1:0] lane_ext_b [NLANES];

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        logic [LANE_W-1:0] la;
        logic [LANE_W-1:0] lb;
        logic [LANE_W-1:0] ls;

        assign la = a_q[gi*LANE_W +: LANE_W];
        assign lb = b_q[gi*LANE_W +: LANE_W];
        assign ls = la + lb;

        assign lane_ext_a[gi] = {{(WIDTH-LANE_W){la[LANE_W-1]}}, la};
        assign lane_ext_b[gi] = {{(WIDTH-LANE_W){lb[LANE_W-1]}}, lb};

`ifdef ALU_SAT_EN
        logic lane_ovf;
        assign lane_ovf = (la[LANE_W-1] == lb[LANE_W-1]) & (ls[LANE_W-1] != la[LANE_W-1]);
        assign padd_res[gi*LANE_W +: LANE_W] =
            lane_ovf ? (la[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}})
                     : ls;
`else
        assign padd_res[gi*LANE_W +: LANE_W] = ls;
`endif
    end

    // Reduction: sum of every sign-extended lane of a and b, modulo 2^WIDTH
    logic [WIDTH-1:0] red_sum;
    always_comb begin
        red_sum = '0;
        for (int i = 0; i < NLANES; i++) begin
            red_sum = red_sum + lane_ext_a[i] + lane_ext_b[i];
        end
    end

    // ------------------------------------------------------------------
    // Shifter: amount is the low SH_W bits of b
    // ------------------------------------------------------------------
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0] ror_res;

    assign sh      = b_q[SH_W-1:0];
    assign sll_res = a_q << sh;
    assign sra_res = $signed(a_q) >>> sh;
    // For sh == 0 the left term shifts out entirely, leaving a unchanged
    assign ror_res = (a_q >> sh) | (a_q << (WIDTH - int'(sh)));

    // Result select and flag generation for stage 2
    always_comb begin
        res_d    = '0;
        flag_v_d = 1'b0;
        flag_n_d = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_d    = addsub_res;
                flag_v_d = addsub_ovf;
                flag_n_d = addsub_res[MSB];
            end
            OP_XOR: res_d = a_q ^ b_q;
            OP_RED: begin
                res_d    = red_sum;
                flag_n_d = red_sum[MSB];
            end
            OP_SLL:  res_d = sll_res;
            OP_SRA:  res_d = sra_res;
            OP_ROR:  res_d = ror_res;
            default: res_d = padd_res;
        endcase
        flag_z_d = ~|res_d;
    end

    // Stage 1: capture operands whenever the stage is free to load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    // Stage 2: register result and flags; hold them while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            flag_z_q   <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= res_d;
                flag_z_q   <= flag_z_d;
                flag_v_q   <= flag_v_d;
                flag_n_q   <= flag_n_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_simd.sv
// tb_alu_pipe_simd: directed vectors for alu_pipe_simd checked against an
// arithmetic reference model (queue-based scoreboard) plus literal expectations.
// Honours ALU_SAT_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_pipe_simd;
    localparam int W  = 16;
    localparam int L  = 4;
    localparam int NL = W / L;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         flag_z;
    logic         flag_v;
    logic         flag_n;

    always #5 clk = ~clk;

    alu_pipe_simd #(.WIDTH(W), .LANE_W(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    typedef struct packed {
        logic [2:0]   fl;    // {z, v, n}
        logic [W-1:0] data;
    } res_t;

    typedef struct {
        res_t       mdl;
        bit         has_lit;
        res_t       lit;
        time        stamp;
        bit         chk_lat;
        logic [2:0] op;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issued = 0;
    int   n_out    = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Sign-interpret the low w bits of x
    function automatic longint sx(input longint x, input int w);
        longint half;
        half = longint'(1) << (w - 1);
        if (x >= half) return x - (half << 1);
        return x;
    endfunction

    // Reference model: plain integer arithmetic on signed/unsigned values
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] av,
                                   input logic [W-1:0] bv);
        longint ua, ub, sa, sb, s, acc, la, lb, mask, lmask, smax, smin, lmax, lmin;
        int     sh;
        logic [W-1:0] d;
        logic   v, n;
        res_t   r;
        ua    = longint'(av);
        ub    = longint'(bv);
        sa    = sx(ua, W);
        sb    = sx(ub, W);
        mask  = (longint'(1) << W) - 1;
        lmask = (longint'(1) << L) - 1;
        smax  = (longint'(1) << (W - 1)) - 1;
        smin  = -smax - 1;
        lmax  = (longint'(1) << (L - 1)) - 1;
        lmin  = -lmax - 1;
        sh    = int'(ub % W);
        d = '0; v = 1'b0; n = 1'b0; s = 0; acc = 0;
        case (o)
            3'd0, 3'd1: begin
                s = (o == 3'd0) ? sa + sb : sa - sb;
                v = (s > smax) || (s < smin);
`ifdef ALU_SAT_EN
                if (s > smax) s = smax;
                else if (s < smin) s = smin;
`endif
                d = W'(s & mask);
                n = d[W-1];
            end
            3'd2: d = av ^ bv;
            3'd3: begin
                for (int l = 0; l < NL; l++)
                    s = s + sx((ua >> (l * L)) & lmask, L) + sx((ub >> (l * L)) & lmask, L);
                d = W'(s & mask);
                n = d[W-1];
            end
            3'd4: d = W'((ua << sh) & mask);
            3'd5: d = W'((sa >>> sh) & mask);
            3'd6: d = W'(((ua >> sh) | (ua << (W - sh))) & mask);
            default: begin
                for (int l = 0; l < NL; l++) begin
                    la = sx((ua >> (l * L)) & lmask, L);
                    lb = sx((ub >> (l * L)) & lmask, L);
                    s  = la + lb;
`ifdef ALU_SAT_EN
                    if (s > lmax) s = lmax;
                    else if (s < lmin) s = lmin;
`endif
                    acc = acc | ((s & lmask) << (l * L));
                end
                d = W'(acc);
            end
        endcase
        r.data = d;
        r.fl   = {(d == '0), v, n};
        return r;
    endfunction

    // Present one operation and hold it until the pipeline accepts it
    task automatic send(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit has_lit, input logic [W-1:0] ld, input logic [2:0] lf,
                        input bit lat);
        exp_t e;
        bit   done;
        done      = 1'b0;
        e.mdl     = model(o, av, bv);
        e.has_lit = has_lit;
        e.lit     = {lf, ld};
        e.chk_lat = lat;
        e.op      = o;
        if (has_lit) chk("model_pin", longint'(e.mdl), longint'(e.lit));
        op = o; a = av; b = bv; in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                e.stamp = $time;
                q.push_back(e);
                n_issued++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    // Single operation into an idle pipeline, with literal result and latency check
    task automatic dir(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ld, input logic [2:0] lf);
        send(o, av, bv, 1'b1, ld, lf, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard compare on every output transfer, hold check on stalls
    initial begin : monitor
        exp_t         e;
        bit           hold_chk;
        logic [W-1:0] hold_d;
        logic [2:0]   hold_f;
        hold_chk = 1'b0;
        hold_d   = '0;
        hold_f   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk)
                    chk("stall_hold", longint'({out_valid, flag_z, flag_v, flag_n, out_data}),
                        longint'({1'b1, hold_f, hold_d}));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", longint'(out_data), -1);
                    end else begin
                        e = q.pop_front();
                        n_out++;
                        $display("out #%0d op=%0d data=%h z=%b v=%b n=%b", n_out, e.op,
                                 out_data, flag_z, flag_v, flag_n);
                        chk("result_vs_model", longint'({flag_z, flag_v, flag_n, out_data}),
                            longint'(e.mdl));
                        if (e.has_lit)
                            chk("result_literal", longint'({flag_z, flag_v, flag_n, out_data}),
                                longint'(e.lit));
                        if (e.chk_lat)
                            chk("latency_cycles", longint'(($time - e.stamp) / 10), 2);
                    end
                end
                hold_chk = out_valid && !out_ready;
                hold_d   = out_data;
                hold_f   = {flag_z, flag_v, flag_n};
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] pa [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h5A5A};
    logic [W-1:0] pb [4] = '{16'h8001, 16'h7FFF, 16'h0001, 16'h000F};

    initial begin : stim
        int base;
        rst = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data",  longint'(out_data), 0);
        chk("reset_flags",     longint'({flag_z, flag_v, flag_n}), 0);
        chk("reset_in_ready",  longint'(in_ready), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, flags written {z,v,n}
`ifdef ALU_SAT_EN
        dir(3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010);
        dir(3'd1, 16'h8000, 16'h0001, 16'h8000, 3'b011);
        dir(3'd7, 16'h7878, 16'h1111, 16'h7979, 3'b000);
        dir(3'd0, 16'h8000, 16'h8000, 16'h8000, 3'b011);
`else
        dir(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b011);
        dir(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
        dir(3'd7, 16'h7878, 16'h1111, 16'h8989, 3'b000);
        dir(3'd0, 16'h8000, 16'h8000, 16'h0000, 3'b110);
`endif
        dir(3'd1, 16'h1234, 16'h1234, 16'h0000, 3'b100);
        dir(3'd3, 16'hFFFF, 16'h0001, 16'hFFFD, 3'b001);
        dir(3'd5, 16'h8000, 16'h0004, 16'hF800, 3'b000);
        dir(3'd6, 16'h0001, 16'h0001, 16'h8000, 3'b000);
        dir(3'd4, 16'h0001, 16'h000F, 16'h8000, 3'b000);
        dir(3'd2, 16'hA5A5, 16'hA5A5, 16'h0000, 3'b100);
        dir(3'd4, 16'h1234, 16'h0000, 16'h1234, 3'b000);
        dir(3'd6, 16'h1234, 16'h0004, 16'h4123, 3'b000);
        dir(3'd3, 16'h7777, 16'h7777, 16'h0038, 3'b000);
        dir(3'd7, 16'hF0F0, 16'h1010, 16'h0000, 3'b100);
        dir(3'd5, 16'h7000, 16'h0013, 16'h0E00, 3'b000);
        dir(3'd1, 16'h0005, 16'h0007, 16'hFFFE, 3'b001);
        dir(3'd0, 16'h0003, 16'h0004, 16'h0007, 3'b000);

        // Back-pressure: four back-to-back XORs while the consumer stalls 3 cycles
        out_ready = 1'b0;
        base = n_issued;
        fork
            begin
                send(3'd2, 16'h1111, 16'h0F0F, 1'b1, 16'h1E1E, 3'b000, 1'b0);
                send(3'd2, 16'h2222, 16'h00FF, 1'b1, 16'h22DD, 3'b000, 1'b0);
                send(3'd2, 16'h3333, 16'hF000, 1'b1, 16'hC333, 3'b000, 1'b0);
                send(3'd2, 16'h4444, 16'h4444, 1'b1, 16'h0000, 3'b100, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", longint'(in_ready), 0);
                chk("bp_accepts",      longint'(n_issued - base), 2);
                chk("bp_hold_first",   longint'({out_valid, out_data}), longint'({1'b1, 16'h1E1E}));
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_consecutive", longint'(out_valid), 1);
                end
            end
        join
        @(posedge clk);
        #1;

        // Full-throughput stream, consumer always ready
        for (int i = 0; i < 8; i++)
            send(3'(i), 16'h9C3A ^ W'(i * 16'h1111), 16'h0005 + W'(i), 1'b0, '0, '0, 1'b1);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Stream under an irregular consumer
        fork
            begin
                for (int o = 0; o < 8; o++)
                    for (int p = 0; p < 4; p++)
                        send(3'(o), pa[p], pb[(p + o) % 4], 1'b0, '0, '0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1 out_ready = (i % 3) != 0;
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("stream_drained", longint'(q.size()), 0);

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(3'd0, 16'h0101, 16'h0202, 1'b0, '0, '0, 1'b0);
        send(3'd2, 16'h00FF, 16'hFF00, 1'b0, '0, '0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_data",  longint'(out_data), 0);
        chk("midrst_flags",     longint'({flag_z, flag_v, flag_n}), 0);
        chk("midrst_in_ready",  longint'(in_ready), 1);
        q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        dir(3'd0, 16'h0100, 16'h0023, 16'h0123, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", longint'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
